avl_read_master: RTL and testbench

AVL_READ_MASTER -- requirements
Module: avl_read_master

---
 rtl/avl_pkg.sv | 16 +
 rtl/avl_rd_fifo.sv | 57 +++++
 rtl/avl_read_master.sv | 146 ++++++++++++++
 tb/tb_avl_read_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon burst-free read master.
// Holds the controller state encoding and the default bus geometry.
package avl_pkg;

    localparam int DEF_XAW = 32;
    localparam int DEF_XDW = 128;
    localparam int BPW     = DEF_XDW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/avl_rd_fifo.sv
// Synchronous show-ahead FIFO buffering read data for the user side.
// The head word is presented combinationally whenever the FIFO is not empty.
module avl_rd_fifo
    import avl_pkg::*;
#(
    parameter int XDW        = avl_pkg::DEF_XDW,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [XDW-1:0]                push_data,
    input  logic                          pop_i,
    output logic [XDW-1:0]                pop_data,
    output logic                          not_empty,
    output logic [$clog2(FIFO_DEPTH):0]   used
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [XDW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_q, wr_d;
    logic [AW:0]    rd_q, rd_d;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign used      = wr_q - rd_q;
    assign not_empty = (wr_q != rd_q);
    assign full      = (used == (AW+1)'(FIFO_DEPTH));
    assign do_pop    = pop_i & not_empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push   = push_i & (~full | do_pop);
    assign pop_data  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/avl_read_master.sv
// Avalon-MM read master: issues single-word reads for a byte range into a user FIFO.
// Define AVL_RD_FIXED_LOCATION_EN to let control_fixed_location freeze the address.
module avl_read_master
#(
    parameter int XAW        = avl_pkg::DEF_XAW,
    parameter int XDW        = avl_pkg::DEF_XDW,
    parameter int FIFO_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               control_fixed_location,
    input  logic [XAW-1:0]     control_read_base,
    input  logic [XAW-1:0]     control_read_length,
    input  logic               control_go,
    output logic               control_done,
    input  logic               user_read_buffer,
    output logic [XDW-1:0]     user_buffer_output_data,
    output logic               user_data_available,
    output logic [XAW-1:0]     master_address,
    output logic               master_read,
    output logic [XDW/8-1:0]   master_byteenable,
    input  logic [XDW-1:0]     master_readdata,
    input  logic               master_readdatavalid,
    input  logic               master_waitrequest
);

    import avl_pkg::*;

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CW      = FIFO_AW + 1;
`ifdef AVL_RD_FIXED_LOCATION_EN
    localparam logic FIXED_EN = 1'b1;
`else
    localparam logic FIXED_EN = 1'b0;
`endif
    localparam logic [XAW-1:0] STEP     = XAW'(XDW / 8);
    localparam logic [XAW-1:0] LEN_MASK = ~(XAW'(XDW / 8) - XAW'(1));
    localparam logic [CW:0]    DEPTH_C  = (CW+1)'(FIFO_DEPTH);

    state_t         state_q, state_d;
    logic [XAW-1:0] addr_q, addr_d;
    logic [XAW-1:0] remain_q, remain_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic           fixed_q, fixed_d;
    logic           read_q, read_d;
    logic           done_q, done_d;

    logic           accept;
    logic           push;
    logic           pop;
    logic [CW-1:0]  fifo_used;
    logic [CW-1:0]  used_next;
    logic [CW:0]    credit;
    logic [XAW-1:0] len_rnd;

    assign accept  = read_q & ~master_waitrequest;
    // Data with nothing outstanding belongs to an aborted transfer and is dropped.
    assign push    = master_readdatavalid & (outst_q != '0);
    assign pop     = user_read_buffer & user_data_available;
    assign len_rnd = control_read_length & LEN_MASK;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        fixed_d   = fixed_q;
        outst_d   = outst_q + CW'(accept) - CW'(push);
        used_next = fifo_used + CW'(push) - CW'(pop);

        if (accept) begin
            remain_d = remain_q - STEP;
            if (!fixed_q) begin
                addr_d = addr_q + STEP;
            end
        end

        case (state_q)
            IDLE: begin
                if (control_go) begin
                    addr_d   = control_read_base;
                    remain_d = len_rnd;
                    fixed_d  = control_fixed_location & FIXED_EN;
                    state_d  = (len_rnd == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (remain_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every issued-but-unreturned word reserves a FIFO slot before it is requested.
        credit = {1'b0, outst_d} + {1'b0, used_next};
        read_d = (read_q & master_waitrequest) |
                 ((state_d == ISSUE) && (remain_d != '0) && (credit < DEPTH_C));
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            outst_q  <= '0;
            fixed_q  <= 1'b0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            outst_q  <= outst_d;
            fixed_q  <= fixed_d;
            read_q   <= read_d;
            done_q   <= done_d;
        end
    end

    assign master_address    = addr_q;
    assign master_read       = read_q;
    assign master_byteenable = '1;
    assign control_done      = done_q;

    avl_rd_fifo #(
        .XDW        (XDW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data  (master_readdata),
        .pop_i      (user_read_buffer),
        .pop_data   (user_buffer_output_data),
        .not_empty  (user_data_available),
        .used       (fifo_used)
    );

endmodule

// File: tb/tb_avl_read_master.sv
// Directed bench for avl_read_master: transfer table plus reset-abort sequence.
module tb_avl_read_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         control_fixed_location;
    logic [31:0]  control_read_base;
    logic [31:0]  control_read_length;
    logic         control_go;
    logic         control_done;
    logic         user_read_buffer;
    logic [127:0] user_buffer_output_data;
    logic         user_data_available;
    logic [31:0]  master_address;
    logic         master_read;
    logic [15:0]  master_byteenable;
    logic [127:0] master_readdata;
    logic         master_readdatavalid;
    logic         master_waitrequest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avl_read_master #(.XAW(32), .XDW(128), .FIFO_DEPTH(32)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .control_fixed_location  (control_fixed_location),
        .control_read_base       (control_read_base),
        .control_read_length     (control_read_length),
        .control_go              (control_go),
        .control_done            (control_done),
        .user_read_buffer        (user_read_buffer),
        .user_buffer_output_data (user_buffer_output_data),
        .user_data_available     (user_data_available),
        .master_address          (master_address),
        .master_read             (master_read),
        .master_byteenable       (master_byteenable),
        .master_readdata         (master_readdata),
        .master_readdatavalid    (master_readdatavalid),
        .master_waitrequest      (master_waitrequest)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        logic        fixed;
        int          stall_idx;
        int          stall_n;
        int          pop_start;
        int          glitch_cyc;
        logic [31:0] exp_a0;
        logic [31:0] exp_step;
        int          exp_nreq;
        int          exp_acc_at_pop;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkdata(input logic [31:0] a, input int idx);
        return {32'hC0DE_0000 | 32'(idx), a, ~a, 32'h1234_0000 + 32'(idx)};
    endfunction

    task automatic idle_inputs();
        control_go           = 1'b0;
        user_read_buffer     = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        master_waitrequest   = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v);
        logic [127:0] sb [$];
        logic [127:0] resp_data;
        logic [127:0] exp_d;
        logic [31:0]  exp_a;
        logic         resp_pend;
        logic         finished;
        int           nreq;
        int           ndone;
        int           stall_left;
        nreq = 0; ndone = 0; stall_left = v.stall_n;
        resp_pend = 1'b0; resp_data = '0; finished = 1'b0;

        @(negedge clk);
        control_read_base      = v.base;
        control_read_length    = v.len;
        control_fixed_location = v.fixed;
        control_go             = 1'b1;

        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            control_go = 1'b0;
            if (cyc == 1) begin
                if (v.exp_nreq > 0) chk("go_to_read_latency", master_read, 1'b1);
                else                chk("zero_len_done_latency", control_done, 1'b1);
            end
            if (control_done) ndone++;
            if (cyc == v.pop_start) begin
                chk("accepted_before_pop", nreq, v.exp_acc_at_pop);
                chk("read_stalled_full", master_read, 1'b0);
            end
            if (v.stall_idx >= 0 && stall_left > 0 && stall_left < v.stall_n)
                chk("stall_read_hold", master_read, 1'b1);

            user_read_buffer = 1'b0;
            if (cyc >= v.pop_start && user_data_available) begin
                if (sb.size() == 0) begin
                    chk("fifo_unexpected_word", user_data_available, 1'b0);
                end else begin
                    exp_d = sb.pop_front();
                    chk("fifo_data", user_buffer_output_data, exp_d);
                end
                user_read_buffer = 1'b1;
            end

            master_readdatavalid = resp_pend;
            master_readdata      = resp_data;
            resp_pend            = 1'b0;

            master_waitrequest = 1'b0;
            if (cyc == v.glitch_cyc) begin
                control_go        = 1'b1;
                control_read_base = 32'hDEAD_0000;
            end
            if (master_read) begin
                exp_a = v.exp_a0 + v.exp_step * 32'(nreq);
                if (nreq == v.stall_idx && stall_left > 0) begin
                    master_waitrequest = 1'b1;
                    stall_left--;
                    chk("stall_addr_hold", master_address, exp_a);
                end else begin
                    chk("req_addr", master_address, exp_a);
                    resp_data = mkdata(master_address, nreq);
                    sb.push_back(resp_data);
                    resp_pend = 1'b1;
                    nreq++;
                end
            end

            if (ndone > 0 && sb.size() == 0 && !user_data_available &&
                !resp_pend && !master_readdatavalid) begin
                finished = 1'b1;
                break;
            end
        end
        chk("xfer_finished", finished, 1'b1);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (control_done) ndone++;
            if (master_read) nreq++;
            idle_inputs();
        end
        chk("done_pulse_count", ndone, 1);
        chk("request_count", nreq, v.exp_nreq);
    endtask

    initial begin
        rst = 1'b0;
        control_fixed_location = 1'b0;
        control_read_base      = '0;
        control_read_length    = '0;
        idle_inputs();

        vecs[0] = '{base:32'h1000, len:32'd64, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'h1000, exp_step:32'h10, exp_nreq:4, exp_acc_at_pop:0};
        vecs[1] = '{base:32'h1000, len:32'd0, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'h1000, exp_step:32'h10, exp_nreq:0, exp_acc_at_pop:0};
        vecs[2] = '{base:32'h1000, len:32'd64, fixed:1'b0, stall_idx:1, stall_n:5, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'h1000, exp_step:32'h10, exp_nreq:4, exp_acc_at_pop:0};
`ifdef AVL_RD_FIXED_LOCATION_EN
        vecs[3] = '{base:32'h2000, len:32'd48, fixed:1'b1, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'h2000, exp_step:32'h0, exp_nreq:3, exp_acc_at_pop:0};
`else
        vecs[3] = '{base:32'h2000, len:32'd48, fixed:1'b1, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'h2000, exp_step:32'h10, exp_nreq:3, exp_acc_at_pop:0};
`endif
        vecs[4] = '{base:32'h500, len:32'd40, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'h500, exp_step:32'h10, exp_nreq:2, exp_acc_at_pop:0};
        vecs[5] = '{base:32'hFFFF_FFE0, len:32'd64, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:-1, exp_a0:32'hFFFF_FFE0, exp_step:32'h10, exp_nreq:4, exp_acc_at_pop:0};
        vecs[6] = '{base:32'h8000, len:32'd1024, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:120,
                    glitch_cyc:-1, exp_a0:32'h8000, exp_step:32'h10, exp_nreq:64, exp_acc_at_pop:32};
        vecs[7] = '{base:32'h6000, len:32'd64, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:0,
                    glitch_cyc:3, exp_a0:32'h6000, exp_step:32'h10, exp_nreq:4, exp_acc_at_pop:0};

        repeat (3) @(negedge clk);
        chk("rst_master_read", master_read, 1'b0);
        chk("rst_master_address", master_address, 32'h0);
        chk("rst_control_done", control_done, 1'b0);
        chk("rst_data_available", user_data_available, 1'b0);
        chk("rst_byteenable", master_byteenable, 16'hFFFF);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i]);
        end

        // Abort mid-transfer: three requests accepted, only the first answered.
        @(negedge clk);
        control_read_base      = 32'h3000;
        control_read_length    = 32'd160;
        control_fixed_location = 1'b0;
        control_go             = 1'b1;
        @(negedge clk);
        control_go = 1'b0;
        chk("abort_req1", master_read, 1'b1);
        @(negedge clk);
        master_readdatavalid = 1'b1;
        master_readdata      = mkdata(32'h3000, 0);
        chk("abort_req2", master_read, 1'b1);
        @(negedge clk);
        master_readdatavalid = 1'b0;
        chk("abort_req3", master_read, 1'b1);
        @(negedge clk);
        chk("abort_word_buffered", user_data_available, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_data_available", user_data_available, 1'b0);
        chk("abort_master_read", master_read, 1'b0);
        chk("abort_master_address", master_address, 32'h0);
        chk("abort_byteenable", master_byteenable, 16'hFFFF);
        rst = 1'b1;
        master_readdatavalid = 1'b1;
        master_readdata      = mkdata(32'h3010, 1);
        @(negedge clk);
        master_readdatavalid = 1'b0;
        @(negedge clk);
        chk("late_data_dropped", user_data_available, 1'b0);

        run_xfer('{base:32'h4000, len:32'd16, fixed:1'b0, stall_idx:-1, stall_n:0, pop_start:0,
                   glitch_cyc:-1, exp_a0:32'h4000, exp_step:32'h10, exp_nreq:1, exp_acc_at_pop:0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
